serial_link_port: RTL and testbench
===================================

SERIAL_LINK_PORT -- requirements
Module: serial_link_port

Interface
REQ-001 SHALL have parameter CLOCK_DIVIDER, default 512, giving iClock cycles per internal serial bit (even, >=4).
REQ-002 SHALL have port iClock  input  1  system clock; all logic on rising edge.
REQ-003 SHALL have port iReset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port iMCUAddr  input  16  CPU memory-bus address.
REQ-005 SHALL have port iMCUWe  input  1  CPU write strobe, one cycle per write.
REQ-006 SHALL have port iMCUData  input  8  CPU write data.
REQ-007 SHALL have port oMCUData  output  8  read data for the addressed register, or 8'hFF when unmapped.
REQ-008 SHALL have port iSerialIn  input  1  serial data in.
REQ-009 SHALL have port oSerialOut  output  1  serial data out.
REQ-010 SHALL have port iSerialClock  input  1  external serial clock, asynchronous.
REQ-011 SHALL have port oSerialClock  output  1  internal serial clock, idle high.
REQ-012 SHALL have port oInterrupt  output  1  serial interrupt request, one-cycle pulse.

Function
REQ-013 SHALL decode SB at 16'hFF01 and SC at 16'hFF02; SHALL ignore all other addresses.
REQ-014 SHALL drive oMCUData combinationally from iMCUAddr: SB gives the shift register; SC gives {busy, 6'b111111, clock_select}; otherwise 8'hFF.
REQ-015 SHALL load SB on a write to SB while idle, and SHALL ignore writes to SB while busy.
REQ-016 SHALL, on an SC write while idle, latch clock_select=iMCUData[0] and, if iMCUData[7]=1, start a transfer on the next cycle.
REQ-017 SHALL abort an active transfer on an SC write with bit7=0: return to IDLE, keep SB as partially shifted, raise no interrupt, and set oSerialClock high. An SC write with bit7=1 while busy SHALL be ignored.
REQ-018 SHALL use the states IDLE, CLK_LOW, CLK_HIGH and DONE.
REQ-019 SHALL make the following transitions: IDLE->CLK_LOW on start; CLK_LOW->CLK_HIGH on a rising clock edge; CLK_HIGH->CLK_LOW on a falling edge while bit_count<8; after the 8th rising edge ->DONE; DONE->IDLE after one cycle.
REQ-020 SHALL, in internal mode (clock_select=1), hold oSerialClock low for CLOCK_DIVIDER/2 cycles and then high for CLOCK_DIVIDER/2 cycles per bit, so that a full byte takes 8*CLOCK_DIVIDER cycles.
REQ-021 SHALL, in external mode (clock_select=0), synchronise iSerialClock with 2 flops and use the detected edges, and SHALL hold oSerialClock high.
REQ-022 SHALL transmit MSB first: oSerialOut=SB[7] is valid from entry to CLK_LOW; on each rising edge SB<={SB[6:0], iSerialIn} and bit_count increments.
REQ-023 SHALL use a 4-bit bit_count that is cleared on start and saturates at 8.
REQ-024 SHALL, in DONE, clear busy and pulse oInterrupt high for exactly one cycle.
REQ-025 SHALL, when a CPU read and an internal SB update coincide, return the pre-update value.

Reset
REQ-026 SHALL, on iReset, set the following for at least one cycle: state=IDLE; SB=8'h00; busy=0; clock_select=0; bit_count=0; divider=0; oSerialOut=1; oSerialClock=1; oInterrupt=0.
REQ-027 SHALL, on iReset mid-transfer, abandon the transfer with no interrupt.

Structure
REQ-028 SHALL place the SB/SC addresses and the state encodings in the shared definitions include, next to the existing memory-map constants.
REQ-029 SHALL implement the 2-flop synchroniser plus edge detector as sub-module serial_clock_sync.
REQ-030 SHALL keep the divider, FSM and shift register in the top module.

Verification
REQ-031 SHALL cover: SB=8'hA5, SC=8'h81, iSerialIn=1 -> oSerialOut sequence 1,0,1,0,0,1,0,1; oInterrupt pulses once 8*CLOCK_DIVIDER+1 cycles after the start; SB reads 8'hFF; SC reads 8'h7F.
REQ-032 SHALL cover: SB=8'h00, SC=8'h80, 8 external pulses on iSerialClock with iSerialIn=1 -> SB reads 8'hFF, one interrupt, oSerialClock stays high.
REQ-033 SHALL cover: a transfer started, with SC=8'h01 written after 3 bits -> SC reads 8'h7F, no interrupt, and no further shifting.
REQ-034 SHALL cover: a write of SB=8'h3C while busy -> SB is unaffected by the write and the transfer completes normally.
REQ-035 SHALL cover: iReset asserted mid-transfer -> SB=8'h00, SC reads 8'h7E, oInterrupt=0.
REQ-036 SHALL cover: reads of 16'hFF00 and 16'hFF03 -> 8'hFF, with no state change.

Source files
------------

// File: rtl/serial_link_port_pkg.sv
// Shared definitions for the serial link port: the serial register addresses
// inside the FF00 I/O page, the transfer state encoding and the SC read-back format.
package serial_link_port_pkg;

  localparam logic [15:0] ADDR_SB = 16'hFF01;
  localparam logic [15:0] ADDR_SC = 16'hFF02;

  localparam logic [3:0] BITS_PER_BYTE = 4'd8;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CLK_LOW  = 2'd1,
    CLK_HIGH = 2'd2,
    DONE     = 2'd3
  } serialState_t;

  // Unused SC bits read back as ones.
  function automatic logic [7:0] scValue(input logic busy, input logic clockSelect);
    return {busy, 6'b111111, clockSelect};
  endfunction

endpackage

// File: rtl/serial_clock_sync.sv
// Brings the asynchronous external serial clock into the iClock domain and
// reports single-cycle rising/falling edge strobes.
module serial_clock_sync (
  input  logic iClock,
  input  logic iReset,
  input  logic iSerialClock,
  output logic oRise,
  output logic oFall
);

  logic [1:0] syncStages;
  logic       lastLevel;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour; blocking here would collapse the chain.
  always_ff @(posedge iClock) begin
    if (iReset) begin
      // Line idles high, so preload high to avoid a false edge after reset.
      syncStages <= 2'b11;
      lastLevel  <= 1'b1;
    end else begin
      syncStages <= {syncStages[0], iSerialClock};
      lastLevel  <= syncStages[1];
    end
  end

  assign oRise = syncStages[1] & ~lastLevel;
  assign oFall = ~syncStages[1] & lastLevel;

endmodule

// File: rtl/serial_link_port.sv
// Byte-wide serial link port: SB shift register and SC control register on the
// CPU bus, internal divided clock or synchronised external clock, one IRQ per byte.
module serial_link_port
  import serial_link_port_pkg::*;
#(
  parameter int CLOCK_DIVIDER = 512
) (
  input  logic        iClock,
  input  logic        iReset,
  input  logic [15:0] iMCUAddr,
  input  logic        iMCUWe,
  input  logic [7:0]  iMCUData,
  output logic [7:0]  oMCUData,
  input  logic        iSerialIn,
  output logic        oSerialOut,
  input  logic        iSerialClock,
  output logic        oSerialClock,
  output logic        oInterrupt
);

  localparam int HALF_PERIOD = CLOCK_DIVIDER / 2;
  localparam int DIV_W       = $clog2(HALF_PERIOD);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(HALF_PERIOD - 1);

  serialState_t   state;
  logic [7:0]     sb;
  logic           busy;
  logic           clockSelect;
  logic           startPending;
  logic [3:0]     bitCount;
  logic [DIV_W-1:0] divider;

  logic extRise;
  logic extFall;
  logic sbWrite;
  logic scWrite;
  logic abortReq;
  logic halfDone;
  logic riseTick;
  logic fallTick;

  serial_clock_sync clockSync (
    .iClock      (iClock),
    .iReset      (iReset),
    .iSerialClock(iSerialClock),
    .oRise       (extRise),
    .oFall       (extFall)
  );

  assign sbWrite  = iMCUWe && (iMCUAddr == ADDR_SB);
  assign scWrite  = iMCUWe && (iMCUAddr == ADDR_SC);
  assign abortReq = scWrite && !iMCUData[7] && busy;

  // Internal mode: each half period of the divider is one serial clock phase.
  assign halfDone = (divider == DIV_LAST);
  assign riseTick = clockSelect ? halfDone : extRise;
  assign fallTick = clockSelect ? halfDone : extFall;

  // Reads come straight from the registers, so a read in the same cycle as a
  // shift sees the value from before that shift.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    oMCUData = 8'hFF;
    if (iMCUAddr == ADDR_SB) begin
      oMCUData = sb;
    end else if (iMCUAddr == ADDR_SC) begin
      oMCUData = scValue(busy, clockSelect);
    end
  end

  always_ff @(posedge iClock) begin
    if (iReset) begin
      state        <= IDLE;
      sb           <= 8'h00;
      busy         <= 1'b0;
      clockSelect  <= 1'b0;
      startPending <= 1'b0;
      bitCount     <= 4'd0;
      divider      <= '0;
      oSerialOut   <= 1'b1;
      oSerialClock <= 1'b1;
      oInterrupt   <= 1'b0;
    end else begin
      oInterrupt <= 1'b0;

      if (sbWrite && !busy) begin
        sb <= iMCUData;
      end

      if (abortReq) begin
        // Abort keeps the partially shifted SB and raises no interrupt.
        state        <= IDLE;
        busy         <= 1'b0;
        startPending <= 1'b0;
        clockSelect  <= iMCUData[0];
        divider      <= '0;
        oSerialClock <= 1'b1;
      end else begin
        if (scWrite && !busy) begin
          clockSelect <= iMCUData[0];
          if (iMCUData[7]) begin
            busy         <= 1'b1;
            startPending <= 1'b1;
          end
        end

        case (state)
          IDLE: begin
            if (startPending) begin
              state        <= CLK_LOW;
              startPending <= 1'b0;
              bitCount     <= 4'd0;
              divider      <= '0;
              oSerialOut   <= sb[7];
              oSerialClock <= ~clockSelect;
            end
          end

          CLK_LOW: begin
            if (riseTick) begin
              state        <= CLK_HIGH;
              sb           <= {sb[6:0], iSerialIn};
              divider      <= '0;
              oSerialClock <= 1'b1;
              if (bitCount != BITS_PER_BYTE) begin
                bitCount <= bitCount + 4'd1;
              end
            end else if (clockSelect) begin
              divider <= divider + DIV_W'(1);
            end
          end

          CLK_HIGH: begin
            // An external master leaves its clock high after the last bit, so
            // there is no falling edge to wait for in that mode.
            if ((bitCount == BITS_PER_BYTE) && !clockSelect) begin
              state      <= DONE;
              busy       <= 1'b0;
              oInterrupt <= 1'b1;
            end else if (fallTick) begin
              divider <= '0;
              if (bitCount < BITS_PER_BYTE) begin
                state        <= CLK_LOW;
                oSerialOut   <= sb[7];
                oSerialClock <= ~clockSelect;
              end else begin
                state      <= DONE;
                busy       <= 1'b0;
                oInterrupt <= 1'b1;
              end
            end else if (clockSelect) begin
              divider <= divider + DIV_W'(1);
            end
          end

          DONE: begin
            state <= IDLE;
          end

          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_serial_link_port.sv
// Randomised bench for serial_link_port with a bit-level reference model of the
// serial byte exchange, interrupt timing and register read-back.
module tb_serial_link_port;

  localparam int D = 8;
  localparam logic [15:0] A_SB = 16'hFF01;
  localparam logic [15:0] A_SC = 16'hFF02;

  logic        iClock = 1'b0;
  logic        iReset = 1'b1;
  logic [15:0] iMCUAddr = 16'h0000;
  logic        iMCUWe = 1'b0;
  logic [7:0]  iMCUData = 8'h00;
  logic [7:0]  oMCUData;
  logic        iSerialIn = 1'b1;
  logic        oSerialOut;
  logic        iSerialClock = 1'b1;
  logic        oSerialClock;
  logic        oInterrupt;

  int total = 0;
  int bad = 0;

  serial_link_port #(.CLOCK_DIVIDER(D)) dut (
    .iClock      (iClock),
    .iReset      (iReset),
    .iMCUAddr    (iMCUAddr),
    .iMCUWe      (iMCUWe),
    .iMCUData    (iMCUData),
    .oMCUData    (oMCUData),
    .iSerialIn   (iSerialIn),
    .oSerialOut  (oSerialOut),
    .iSerialClock(iSerialClock),
    .oSerialClock(oSerialClock),
    .oInterrupt  (oInterrupt)
  );

  always #5 iClock = ~iClock;

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Called at a falling edge; the address is applied and the mux sampled 1 ns later.
  task automatic checkReg(input string tag, input logic [15:0] addr, input logic [7:0] exp);
    iMCUAddr = addr;
    #1;
    check(tag, int'(oMCUData), int'(exp));
  endtask

  // Called at a falling edge; returns at the falling edge after the write edge.
  task automatic writeReg(input logic [15:0] addr, input logic [7:0] data);
    iMCUAddr = addr;
    iMCUData = data;
    iMCUWe   = 1'b1;
    @(negedge iClock);
    iMCUWe   = 1'b0;
    iMCUAddr = 16'h0000;
  endtask

  // One internally clocked byte. abortAt >= 0 aborts after that many bits;
  // busyWrite tries to overwrite SB mid-transfer.
  task automatic runInternal(input string tag, input logic [7:0] sbInit,
                             input logic [7:0] rxBits, input int abortAt,
                             input bit busyWrite);
    int irqCount;
    int irqCycle;
    int sclkErr;
    int lastN;
    int activeEnd;
    int phase;
    logic expSclk;
    logic [7:0] seenOut;
    logic [7:0] expSb;
    irqCount  = 0;
    irqCycle  = -1;
    sclkErr   = 0;
    seenOut   = 8'h00;
    activeEnd = (abortAt < 0) ? 8 * D : abortAt * D;
    lastN     = (abortAt < 0) ? 8 * D + 4 : abortAt * D + 2 * D;
    expSb     = (abortAt < 0) ? rxBits
                              : 8'((sbInit << abortAt) | (rxBits >> (8 - abortAt)));

    writeReg(A_SB, sbInit);
    iSerialIn = rxBits[7];
    writeReg(A_SC, 8'h81);
    for (int n = 1; n <= lastN; n++) begin
      @(negedge iClock);
      phase   = (n - 1) % D;
      expSclk = (n <= activeEnd) ? ((phase < D / 2) ? 1'b0 : 1'b1) : 1'b1;
      if (oSerialClock !== expSclk) sclkErr++;
      if (oInterrupt === 1'b1) begin
        irqCount++;
        irqCycle = n;
      end
      if (n <= activeEnd && phase == D / 4) seenOut[7 - (n - 1) / D] = oSerialOut;

      iMCUWe = 1'b0;
      if (n <= activeEnd) begin
        if (phase == 0) iSerialIn = rxBits[7 - (n - 1) / D];
      end else begin
        iSerialIn = ~iSerialIn;
      end
      if (abortAt >= 0 && n == abortAt * D) begin
        iMCUAddr = A_SC;
        iMCUData = 8'h01;
        iMCUWe   = 1'b1;
      end
      if (busyWrite && n == 3 * D + 2) begin
        iMCUAddr = A_SB;
        iMCUData = 8'h3C;
        iMCUWe   = 1'b1;
      end
    end
    iMCUWe = 1'b0;

    check({tag, " sclk_shape"}, sclkErr, 0);
    if (abortAt < 0) begin
      check({tag, " sout"}, int'(seenOut), int'(sbInit));
      check({tag, " irq_count"}, irqCount, 1);
      check({tag, " irq_cycle"}, irqCycle, 8 * D + 1);
    end else begin
      check({tag, " sout_partial"}, int'(seenOut >> (8 - abortAt)), int'(sbInit >> (8 - abortAt)));
      check({tag, " irq_count"}, irqCount, 0);
    end
    checkReg({tag, " sb"}, A_SB, expSb);
    checkReg({tag, " sc"}, A_SC, 8'h7F);
  endtask

  task automatic runExternal();
    int irqCount;
    int sclkErr;
    irqCount = 0;
    sclkErr  = 0;
    writeReg(A_SB, 8'h00);
    writeReg(A_SC, 8'h80);
    iSerialIn = 1'b1;
    for (int p = 0; p < 8; p++) begin
      for (int c = 0; c < 8; c++) begin
        @(negedge iClock);
        if (oSerialClock !== 1'b1) sclkErr++;
        if (oInterrupt === 1'b1) irqCount++;
        iSerialClock = (c < 4) ? 1'b0 : 1'b1;
      end
    end
    for (int c = 0; c < 12; c++) begin
      @(negedge iClock);
      if (oSerialClock !== 1'b1) sclkErr++;
      if (oInterrupt === 1'b1) irqCount++;
    end
    check("ext sclk_high", sclkErr, 0);
    check("ext irq_count", irqCount, 1);
    checkReg("ext sb", A_SB, 8'hFF);
    checkReg("ext sc", A_SC, 8'h7E);
  endtask

  task automatic runResetMid();
    int irqCount;
    irqCount = 0;
    writeReg(A_SB, 8'h5A);
    writeReg(A_SC, 8'h81);
    repeat (3 * D + 3) @(negedge iClock);
    iReset = 1'b1;
    repeat (2) @(negedge iClock);
    iReset = 1'b0;
    check("rst_mid irq", int'(oInterrupt), 0);
    check("rst_mid sclk", int'(oSerialClock), 1);
    check("rst_mid sout", int'(oSerialOut), 1);
    checkReg("rst_mid sb", A_SB, 8'h00);
    checkReg("rst_mid sc", A_SC, 8'h7E);
    for (int n = 0; n < 9 * D; n++) begin
      @(negedge iClock);
      if (oInterrupt === 1'b1) irqCount++;
    end
    check("rst_mid no_irq", irqCount, 0);
  endtask

  initial begin
    logic [7:0] rSb;
    logic [7:0] rRx;

    repeat (3) @(negedge iClock);
    iReset = 1'b0;
    check("reset sout", int'(oSerialOut), 1);
    check("reset sclk", int'(oSerialClock), 1);
    check("reset irq", int'(oInterrupt), 0);
    checkReg("reset sb", A_SB, 8'h00);
    checkReg("reset sc", A_SC, 8'h7E);

    writeReg(A_SB, 8'h96);
    checkReg("unmapped ff00", 16'hFF00, 8'hFF);
    checkReg("unmapped ff03", 16'hFF03, 8'hFF);
    writeReg(16'hFF00, 8'h55);
    writeReg(16'hFF03, 8'h81);
    checkReg("unmapped sb_kept", A_SB, 8'h96);
    checkReg("unmapped sc_kept", A_SC, 8'h7E);
    check("unmapped sclk", int'(oSerialClock), 1);

    runInternal("a5", 8'hA5, 8'hFF, -1, 1'b0);
    runExternal();

    for (int t = 0; t < 3; t++) begin
      rSb = 8'($urandom_range(0, 255));
      rRx = 8'($urandom_range(0, 255));
      runInternal($sformatf("rand%0d", t), rSb, rRx, -1, 1'b0);
    end

    rSb = 8'($urandom_range(0, 255));
    rRx = 8'($urandom_range(0, 255));
    runInternal("abort", rSb, rRx, 3, 1'b0);

    rSb = 8'($urandom_range(0, 255));
    rRx = 8'($urandom_range(0, 255));
    runInternal("busy_sb", rSb, rRx, -1, 1'b1);

    runResetMid();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
